// File: rtl/pox_pkg.sv
// Shared constants for the multi-channel pulse-oximeter calibration controller.
// FSM encodings, default widths and channel indices.
package pox_pkg;

  localparam int NUM_CH_D = 2;
  localparam int ADC_W_D  = 8;
  localparam int DC_W_D   = 7;
  localparam int PGA_W_D  = 4;

  localparam int CH_RED = 0;
  localparam int CH_IR  = 1;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SETTLE   = 4'd1;
  localparam logic [3:0] ST_DC_ACC   = 4'd2;
  localparam logic [3:0] ST_DC_EVAL  = 4'd3;
  localparam logic [3:0] ST_PGA_ACC  = 4'd4;
  localparam logic [3:0] ST_PGA_EVAL = 4'd5;
  localparam logic [3:0] ST_NEXT_CH  = 4'd6;
  localparam logic [3:0] ST_OPERATE  = 4'd7;
  localparam logic [3:0] ST_FAIL     = 4'd8;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pox_multi_ch_calib_ctrl_if.sv
// Sample stream into the window statistics block and its results.
// Master feeds samples and clear; slave returns sum/min/max/done.
interface pox_multi_ch_calib_ctrl_if #(
  parameter int ADC_W = 8,
  parameter int SUM_W = 13
);
  logic [ADC_W-1:0] sample;
  logic             valid;
  logic             clear;
  logic [SUM_W-1:0] sum;
  logic [ADC_W-1:0] mn;
  logic [ADC_W-1:0] mx;
  logic             done;

  modport master (
    output sample, valid, clear,
    input  sum, mn, mx, done
  );

  modport slave (
    input  sample, valid, clear,
    output sum, mn, mx, done
  );
endinterface

// File: rtl/pox_win_stats.sv
// Windowed sum/min/max over WIN valid samples; freezes once full.
// Shared by the DC and PGA search phases.
module pox_win_stats
  import pox_pkg::*;
#(
  parameter int ADC_W = 8,
  parameter int WIN   = 27,
  parameter int SUM_W = 13
) (
  input logic CLK,
  input logic rst_n,
  pox_multi_ch_calib_ctrl_if.slave s
);

  localparam int CNT_W = cw(WIN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ADC_W-1:0] mn_q, mn_d;
  logic [ADC_W-1:0] mx_q, mx_d;
  logic             full;

  assign full = (cnt_q == CNT_W'(WIN));

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    mn_d  = mn_q;
    mx_d  = mx_q;
    if (s.clear) begin
      cnt_d = '0;
      sum_d = '0;
      mn_d  = '1;
      mx_d  = '0;
    end else if (s.valid && !full) begin
      cnt_d = cnt_q + 1'b1;
      sum_d = sum_q + SUM_W'(s.sample);
      if (s.sample < mn_q) mn_d = s.sample;
      if (s.sample > mx_q) mx_d = s.sample;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      mn_q  <= '1;
      mx_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      mn_q  <= mn_d;
      mx_q  <= mx_d;
    end
  end

  assign s.sum  = sum_q;
  assign s.mn   = mn_q;
  assign s.mx   = mx_q;
  assign s.done = full;

endmodule

// File: rtl/pox_multi_ch_calib_ctrl.sv
// Per-channel DC-comp and PGA search, then time-multiplexed operation.
// Sits between the ADC and the LED/DC-DAC/PGA front-end.
module pox_multi_ch_calib_ctrl
  import pox_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_D,
  parameter int ADC_W   = ADC_W_D,
  parameter int DC_W    = DC_W_D,
  parameter int PGA_W   = PGA_W_D,
  parameter int WIN     = 27,
  parameter int SETTLE  = 2,
  parameter int DC_LO   = 110,
  parameter int DC_HI   = 145,
  parameter int CLIP_LO = 10,
  parameter int CLIP_HI = 245,
  parameter int SLOT    = 10,
  localparam int CH_W   = cw(NUM_CH)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  ADC,
  input  logic              adc_valid,
  input  logic              Find_setting,
  output logic [NUM_CH-1:0] LED_EN,
  output logic [DC_W-1:0]   DC_Comp,
  output logic [PGA_W-1:0]  PGA_Gain,
  output logic              calib_busy,
  output logic              calib_done,
  output logic              calib_fail,
  output logic [CH_W-1:0]   fail_ch,
  output logic [ADC_W-1:0]  ch_value,
  output logic [CH_W-1:0]   ch_idx,
  output logic              ch_valid
);

  localparam int SUM_W = ADC_W + $clog2(WIN + 1);
  localparam int SC_W  = cw(SETTLE + 1);
  localparam int SL_W  = cw(SLOT);
  localparam logic [31:0] LO_TH = 32'(DC_LO * WIN);
  localparam logic [31:0] HI_TH = 32'((DC_HI + 1) * WIN);
  localparam logic [DC_W-1:0]  DC_MAX  = '1;
  localparam logic [PGA_W-1:0] PGA_MAX = '1;

  logic [3:0]        state_q, state_d;
  logic              pga_ph_q, pga_ph_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic [PGA_W-1:0]  pga_q, pga_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [SL_W-1:0]   slot_q, slot_d;
  logic [CH_W-1:0]   opch_q, opch_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic [SC_W-1:0]   vc_q, vc_d;
  logic [ADC_W-1:0]  held_q, held_d;
  logic              hv_q, hv_d;
  logic [ADC_W-1:0]  cv_q, cv_d;
  logic [CH_W-1:0]   ci_q, ci_d;
  logic              cs_q, cs_d;
  logic [DC_W-1:0]   dc_mem_q [NUM_CH];
  logic [DC_W-1:0]   dc_mem_d [NUM_CH];
  logic [PGA_W-1:0]  pga_mem_q [NUM_CH];
  logic [PGA_W-1:0]  pga_mem_d [NUM_CH];

  logic [31:0]       sum32;
  logic              clipped;
  logic              elig;
  logic              in_cal;
  logic [CH_W-1:0]   nxt_ch;

  pox_multi_ch_calib_ctrl_if #(
    .ADC_W (ADC_W),
    .SUM_W (SUM_W)
  ) st_if ();

  assign st_if.sample = ADC;
  assign st_if.valid  = adc_valid &&
    (state_q == ST_DC_ACC || state_q == ST_PGA_ACC);
  assign st_if.clear  = (state_q == ST_SETTLE);

  pox_win_stats #(
    .ADC_W (ADC_W),
    .WIN   (WIN),
    .SUM_W (SUM_W)
  ) u_stats (
    .CLK   (CLK),
    .rst_n (rst_n),
    .s     (st_if)
  );

  assign sum32   = 32'(st_if.sum);
  assign clipped = (st_if.mn <= ADC_W'(CLIP_LO)) ||
                   (st_if.mx >= ADC_W'(CLIP_HI));
  assign elig    = adc_valid && (vc_q == SC_W'(SETTLE));
  assign nxt_ch  = (opch_q == CH_W'(NUM_CH - 1)) ? '0
                 : opch_q + 1'b1;
  assign in_cal  = state_q inside {ST_SETTLE, ST_DC_ACC,
    ST_DC_EVAL, ST_PGA_ACC, ST_PGA_EVAL, ST_NEXT_CH};

  always_comb begin
    state_d   = state_q;
    pga_ph_d  = pga_ph_q;
    ch_d      = ch_q;
    dc_d      = dc_q;
    pga_d     = pga_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    fch_d     = fch_q;
    sc_d      = sc_q;
    slot_d    = slot_q;
    opch_d    = opch_q;
    led_d     = led_q;
    vc_d      = vc_q;
    held_d    = held_q;
    hv_d      = hv_q;
    cv_d      = cv_q;
    ci_d      = ci_q;
    cs_d      = 1'b0;
    dc_mem_d  = dc_mem_q;
    pga_mem_d = pga_mem_q;
    if (Find_setting) begin
      state_d  = ST_SETTLE;
      pga_ph_d = 1'b0;
      ch_d     = '0;
      dc_d     = '0;
      pga_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      fail_d   = 1'b0;
      sc_d     = '0;
      slot_d   = '0;
      opch_d   = '0;
      led_d    = '0;
      vc_d     = '0;
      hv_d     = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (adc_valid) begin
            if (sc_q == SC_W'(SETTLE - 1)) begin
              sc_d    = '0;
              state_d = pga_ph_q ? ST_PGA_ACC : ST_DC_ACC;
            end else begin
              sc_d = sc_q + 1'b1;
            end
          end
        end
        ST_DC_ACC: begin
          if (st_if.done) state_d = ST_DC_EVAL;
        end
        ST_DC_EVAL: begin
          // A step that would leave the code range is a failed search
          if (sum32 < LO_TH) begin
            if (dc_q == '0) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              busy_d  = 1'b0;
              fch_d   = ch_q;
            end else begin
              dc_d    = dc_q - 1'b1;
              state_d = ST_SETTLE;
            end
          end else if (sum32 >= HI_TH) begin
            if (dc_q == DC_MAX) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              busy_d  = 1'b0;
              fch_d   = ch_q;
            end else begin
              dc_d    = dc_q + 1'b1;
              state_d = ST_SETTLE;
            end
          end else begin
            dc_mem_d[ch_q] = dc_q;
            pga_d    = '0;
            pga_ph_d = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
        ST_PGA_ACC: begin
          if (st_if.done) state_d = ST_PGA_EVAL;
        end
        ST_PGA_EVAL: begin
          if (clipped) begin
            pga_mem_d[ch_q] = (pga_q == '0) ? '0 : pga_q - 1'b1;
            state_d = ST_NEXT_CH;
          end else if (pga_q == PGA_MAX) begin
            pga_mem_d[ch_q] = pga_q;
            state_d = ST_NEXT_CH;
          end else begin
            pga_d   = pga_q + 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_NEXT_CH: begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = ST_OPERATE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            slot_d  = '0;
            opch_d  = '0;
            vc_d    = '0;
            hv_d    = 1'b0;
            led_d   = NUM_CH'(1);
            dc_d    = dc_mem_q[CH_RED];
            pga_d   = pga_mem_q[CH_RED];
          end else begin
            ch_d     = ch_q + 1'b1;
            dc_d     = '0;
            pga_d    = '0;
            pga_ph_d = 1'b0;
            state_d  = ST_SETTLE;
          end
        end
        ST_OPERATE: begin
          if (adc_valid && vc_q != SC_W'(SETTLE)) vc_d = vc_q + 1'b1;
          if (elig) begin
            held_d = ADC;
            hv_d   = 1'b1;
          end
          // Next slot's settings are loaded so they show from slot cycle 0
          if (slot_q == SL_W'(SLOT - 1)) begin
            if (elig || hv_q) begin
              cs_d = 1'b1;
              cv_d = elig ? ADC : held_q;
              ci_d = opch_q;
            end
            slot_d = '0;
            vc_d   = '0;
            hv_d   = 1'b0;
            opch_d = nxt_ch;
            led_d  = NUM_CH'(1) << nxt_ch;
            dc_d   = dc_mem_q[nxt_ch];
            pga_d  = pga_mem_q[nxt_ch];
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pga_ph_q  <= 1'b0;
      ch_q      <= '0;
      dc_q      <= '0;
      pga_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      fch_q     <= '0;
      sc_q      <= '0;
      slot_q    <= '0;
      opch_q    <= '0;
      led_q     <= '0;
      vc_q      <= '0;
      held_q    <= '0;
      hv_q      <= 1'b0;
      cv_q      <= '0;
      ci_q      <= '0;
      cs_q      <= 1'b0;
      dc_mem_q  <= '{default: '0};
      pga_mem_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pga_ph_q  <= pga_ph_d;
      ch_q      <= ch_d;
      dc_q      <= dc_d;
      pga_q     <= pga_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      fch_q     <= fch_d;
      sc_q      <= sc_d;
      slot_q    <= slot_d;
      opch_q    <= opch_d;
      led_q     <= led_d;
      vc_q      <= vc_d;
      held_q    <= held_d;
      hv_q      <= hv_d;
      cv_q      <= cv_d;
      ci_q      <= ci_d;
      cs_q      <= cs_d;
      dc_mem_q  <= dc_mem_d;
      pga_mem_q <= pga_mem_d;
    end
  end

  assign LED_EN = in_cal ? (NUM_CH'(1) << ch_q)
                : (state_q == ST_OPERATE) ? led_q
                : '0;
  assign DC_Comp    = dc_q;
  assign PGA_Gain   = pga_q;
  assign calib_busy = busy_q;
  assign calib_done = done_q;
  assign calib_fail = fail_q;
  assign fail_ch    = fch_q;
  assign ch_value   = cv_q;
  assign ch_idx     = ci_q;
  assign ch_valid   = cs_q;

endmodule
